// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - record/playback sequencer between key encoder and tone generator
// Live codes are debounced on a free-running tick; events are (code, duration-in-ticks) pairs.
module note_sequencer #(
  parameter int DEPTH     = 64,
  parameter int DUR_W     = 16,
  parameter int TICK_DIV  = 50000,
  parameter int DEB_TICKS = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [4:0]                   key_code,
  input  logic                         rec_n,
  input  logic                         play_n,
  input  logic                         stop_n,
  output logic [4:0]                   note_out,
  output logic [1:0]                   state_out,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   evt_count
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DBW = $clog2(DEB_TICKS+1);
  localparam int EW  = 5 + DUR_W;
  localparam logic [4:0] SILENCE = 5'b11111;

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_REC = 2'b01, S_PLAY = 2'b10} state_t;

  state_t            state;
  logic [4:0]        key_s1, key_s2;
  logic [2:0]        btn_s1, btn_s2, btn_d;
  logic [2:0]        press;
  logic              stop_p, rec_p, play_p;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [4:0]        cand, stable;
  logic [DBW-1:0]    deb_cnt, deb_next;
  logic              chg;
  logic [4:0]        cur_code;
  logic [DUR_W-1:0]  dur, dur_plus, pdur, pcnt;
  logic [AW-1:0]     addr, rd_addr;
  logic              pload;
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     rd_data, wr_data;
  logic              wr_en, rd_en, sat, rec_close, full_hit, last, pdone, idle_rec, play_go;

  // Buttons packed as {stop, rec, play}; a press is a falling edge of the synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= SILENCE;
      key_s2 <= SILENCE;
      btn_s1 <= 3'b111;
      btn_s2 <= 3'b111;
      btn_d  <= 3'b111;
    end else begin
      key_s1 <= key_code;
      key_s2 <= key_s1;
      btn_s1 <= {stop_n, rec_n, play_n};
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  assign press  = btn_d & ~btn_s2;
  assign stop_p = press[2];
  assign rec_p  = press[1];
  assign play_p = press[0];
  assign tick   = (tick_cnt == TW'(TICK_DIV-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  always_comb begin
    deb_next = DBW'(1);
    if (key_s2 == cand)
      deb_next = (deb_cnt == DBW'(DEB_TICKS)) ? deb_cnt : deb_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand    <= SILENCE;
      stable  <= SILENCE;
      deb_cnt <= '0;
      chg     <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (tick) begin
        cand    <= key_s2;
        deb_cnt <= deb_next;
        if (deb_next >= DBW'(DEB_TICKS) && key_s2 != stable) begin
          stable <= key_s2;
          chg    <= 1'b1;
        end
      end
    end
  end

  // A change, saturation and stop landing together close the event with a single write.
  always_comb begin
    dur_plus  = tick ? dur + 1'b1 : dur;
    sat       = tick && (dur_plus == '1);
    rec_close = (state == S_REC) && (chg || sat || stop_p);
    wr_en     = rec_close && (dur_plus != '0);
    wr_data   = {cur_code, dur_plus};
    full_hit  = wr_en && (evt_count == CW'(DEPTH-1));
    idle_rec  = !stop_p && rec_p;
    play_go   = !stop_p && !rec_p && play_p && (evt_count != '0);
    last      = (CW'(addr) == evt_count - 1'b1);
    pdone     = (state == S_PLAY) && !pload && tick && ((pcnt + 1'b1) == pdur);
    rd_en     = ((state == S_IDLE) && play_go) || (pdone && !last);
    rd_addr   = (state == S_IDLE) ? '0 : addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[evt_count[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      note_out  <= SILENCE;
      full      <= 1'b0;
      evt_count <= '0;
      cur_code  <= SILENCE;
      dur       <= '0;
      addr      <= '0;
      pcnt      <= '0;
      pdur      <= '0;
      pload     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          note_out <= stable;
          if (idle_rec) begin
            state     <= S_REC;
            evt_count <= '0;
            full      <= 1'b0;
            cur_code  <= stable;
            dur       <= '0;
          end else if (play_go) begin
            state <= S_PLAY;
            addr  <= '0;
            pload <= 1'b1;
          end
        end
        S_REC: begin
          note_out <= stable;
          dur      <= rec_close ? '0 : dur_plus;
          if (chg)   cur_code  <= stable;
          if (wr_en) evt_count <= evt_count + 1'b1;
          if (full_hit) begin
            full  <= 1'b1;
            state <= S_IDLE;
          end else if (stop_p) begin
            state <= S_IDLE;
          end
        end
        S_PLAY: begin
          if (stop_p) begin
            state    <= S_IDLE;
            note_out <= stable;
            pload    <= 1'b0;
          end else if (pload) begin
            note_out <= rd_data[EW-1:DUR_W];
            pdur     <= rd_data[DUR_W-1:0];
            pcnt     <= '0;
            pload    <= 1'b0;
          end else if (tick) begin
            if (pdone) begin
              if (last) begin
                state <= S_IDLE;
              end else begin
                addr  <= addr + 1'b1;
                pload <= 1'b1;
              end
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed bench for note_sequencer (TICK_DIV=4, DEB_TICKS=2, DEPTH=4, DUR_W=4)
// Time t counts rising edges since reset release; inputs change and outputs are sampled on falling edges.
module tb_note_sequencer;

  logic       clk;
  logic       rst_n;
  logic [4:0] key_code;
  logic       rec_n, play_n, stop_n;
  logic [4:0] note_out;
  logic [1:0] state_out;
  logic       full;
  logic [2:0] evt_count;

  int t;
  int vectors;
  int miscompares;

  note_sequencer #(
    .DEPTH(4), .DUR_W(4), .TICK_DIV(4), .DEB_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code),
    .rec_n(rec_n), .play_n(play_n), .stop_n(stop_n),
    .note_out(note_out), .state_out(state_out), .full(full), .evt_count(evt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at t=%0d: observed %0h, expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic to(input int n);
    while (t < n) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n    = 1'b0;
    key_code = 5'b11111;
    {stop_n, rec_n, play_n} = 3'b111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
  endtask

  // m = {stop, rec, play}; buttons held low for two cycles
  task automatic push(input logic [2:0] m, input int at);
    to(at);
    {stop_n, rec_n, play_n} = ~m;
    to(at + 2);
    {stop_n, rec_n, play_n} = 3'b111;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    t = 0;
    rst_n = 1'b1;
    key_code = 5'b11111;
    {stop_n, rec_n, play_n} = 3'b111;

    // reset values and live passthrough with a one-tick glitch
    reset_dut();
    chk("rst_note", note_out, 5'b11111);
    chk("rst_state", state_out, 2'b00);
    chk("rst_full", full, 1'b0);
    chk("rst_evt", evt_count, 3'd0);
    key_code = 5'b10010;
    to(8);  chk("live_before", note_out, 5'b11111);
    to(9);  chk("live_after", note_out, 5'b10010);
    to(10); key_code = 5'b00001;
    to(14); key_code = 5'b10010;
    to(30); chk("glitch_ignored", note_out, 5'b10010);

    // record two events then replay them
    reset_dut();
    key_code = 5'b00000;
    push(3'b010, 10);
    to(14); chk("rec_state", state_out, 2'b01);
    to(24); key_code = 5'b01011;
    to(43); key_code = 5'b11111;
    push(3'b100, 43);
    to(47);
    chk("rec_evt", evt_count, 3'd2);
    chk("rec_stop_state", state_out, 2'b00);
    chk("rec_full", full, 1'b0);
    push(3'b001, 53);
    to(56); chk("play_entry_note", note_out, 5'b11111);
    to(57); chk("play_e0_start", note_out, 5'b00000);
            chk("play_state", state_out, 2'b10);
    to(76); chk("play_e0_end", note_out, 5'b00000);
    to(77); chk("play_e1_start", note_out, 5'b01011);
    to(88); chk("play_e1_end", note_out, 5'b01011);
            chk("play_done_state", state_out, 2'b00);
    to(89); chk("play_revert", note_out, 5'b11111);

    // fill the buffer
    reset_dut();
    key_code = 5'b00000;
    push(3'b010, 10);
    to(16); key_code = 5'b00001;
    to(28); key_code = 5'b00010;
    to(40); key_code = 5'b00011;
    to(52); key_code = 5'b00100;
    to(60);
    chk("prefull_evt", evt_count, 3'd3);
    chk("prefull_full", full, 1'b0);
    to(61);
    chk("full_flag", full, 1'b1);
    chk("full_state", state_out, 2'b00);
    chk("full_evt", evt_count, 3'd4);
    to(64); key_code = 5'b00101;
    to(80); chk("fifth_not_stored", evt_count, 3'd4);

    // priority and ignored presses
    push(3'b011, 82);
    to(86);
    chk("rec_wins_state", state_out, 2'b01);
    chk("rec_clears_full", full, 1'b0);
    chk("rec_clears_evt", evt_count, 3'd0);
    push(3'b001, 90);
    to(96); chk("play_in_rec_ignored", state_out, 2'b01);
    push(3'b100, 100);
    to(106);
    chk("stop_to_idle", state_out, 2'b00);
    chk("stop_final_write", evt_count, 3'd1);
    reset_dut();
    push(3'b001, 2);
    to(8); chk("play_empty_ignored", state_out, 2'b00);

    // duration saturation and replay of the split events
    reset_dut();
    key_code = 5'b00100;
    push(3'b010, 10);
    to(71); chk("sat_pre_evt", evt_count, 3'd0);
    to(73);
    chk("sat_evt", evt_count, 3'd1);
    chk("sat_state", state_out, 2'b01);
    to(91); key_code = 5'b11111;
    push(3'b100, 91);
    to(95);
    chk("sat_stop_evt", evt_count, 3'd2);
    chk("sat_stop_state", state_out, 2'b00);
    push(3'b001, 105);
    to(108); chk("sat_play_pre", note_out, 5'b11111);
    to(109); chk("sat_play_start", note_out, 5'b00100);
    to(169); chk("sat_play_mid", note_out, 5'b00100);
    to(188);
    chk("sat_play_end", note_out, 5'b00100);
    chk("sat_play_done", state_out, 2'b00);
    to(189); chk("sat_play_revert", note_out, 5'b11111);

    // asynchronous reset during playback
    push(3'b001, 193);
    to(200);
    chk("arst_playing", state_out, 2'b10);
    chk("arst_play_note", note_out, 5'b00100);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_note", note_out, 5'b11111);
    chk("arst_state", state_out, 2'b00);
    chk("arst_evt", evt_count, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
